// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: key-driven write sweep / paced read scan sequencer for a single-port RAM.
// Optional readback checker enabled by defining RAM_CHECK_EN.
module ram_seq_ctrl #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter int unsigned CNT_MAX = 9_999_999
`ifdef RAM_CHECK_EN
  , parameter int        RD_LAT  = 2
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key1_flag,
  input  logic              key2_flag,
`ifdef RAM_CHECK_EN
  input  logic [DATA_W-1:0] rd_q,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
`endif
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  localparam int CW = CNT_MAX > 0 ? $clog2(CNT_MAX + 1) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, READ, PAUSE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d, busy_q, busy_d;
  logic              wr_entry, rd_last;
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // key1 outranks key2 everywhere; both are ignored until the sweep finishes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = key1_flag ? WRITE : key2_flag ? READ : IDLE;
      WRITE: state_d = &addr_q ? READ : WRITE;
      READ:  state_d = key1_flag ? WRITE : key2_flag ? PAUSE : READ;
      PAUSE: state_d = key1_flag ? WRITE : key2_flag ? READ : PAUSE;
    endcase
  end
  always_comb begin
    wr_entry = state_d == WRITE && state_q != WRITE;
    rd_last  = cnt_q == CW'(CNT_MAX);
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    if (state_d == WRITE) begin
      addr_d = wr_entry ? '0 : addr_q + 1'b1;
      cnt_d  = '0;
    end else if (state_d == READ && (state_q == IDLE || state_q == WRITE)) begin
      addr_d = '0;
      cnt_d  = '0;
    end else if (state_d == READ && state_q == READ) begin
      cnt_d  = rd_last ? '0 : cnt_q + 1'b1;
      addr_d = rd_last ? addr_q + 1'b1 : addr_q;
    end
    data_d  = state_d == WRITE ? DATA_W'(addr_d) : data_q;
    wr_en_d = state_d == WRITE;
    busy_d  = state_d == WRITE;
    rd_en_d = state_d == READ || state_d == PAUSE;
  end
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
    end
  assign wr_en = wr_en_q;
  assign rd_en = rd_en_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign busy  = busy_q;
`ifdef RAM_CHECK_EN
  // delay line aligns each issued address with the RAM word returned RD_LAT cycles later
  logic [ADDR_W-1:0] pa_q [RD_LAT];
  logic [RD_LAT-1:0] pr_q;
  logic              err_q, chk;
  logic [ADDR_W-1:0] err_addr_q;
  assign chk = pr_q[RD_LAT-1] && (state_q == READ || state_q == PAUSE) &&
               rd_q != DATA_W'(pa_q[RD_LAT-1]);
  always_ff @(posedge sys_clk)
    if (!sys_rst_n || wr_entry) begin
      for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
      pr_q       <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      pa_q[0] <= addr_q;
      pr_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pa_q[i] <= pa_q[i-1];
        pr_q[i] <= pr_q[i-1];
      end
      if (chk && !err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= pa_q[RD_LAT-1];
      end
    end
  assign err      = err_q;
  assign err_addr = err_addr_q;
`endif
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: directed self-checking bench for ram_seq_ctrl (CNT_MAX=3).
// Inputs change and outputs are sampled on the falling edge.
module tb_ram_seq_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          key1_flag = 1'b0;
  logic          key2_flag = 1'b0;
  logic          wr_en, rd_en, busy;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  int            checks = 0;
  int            errors = 0;
  int            n;
`ifdef RAM_CHECK_EN
  logic [DW-1:0] mem [256];
  logic [DW-1:0] r1, rd_q;
  logic          err;
  logic [AW-1:0] err_addr;
  // two-cycle RAM whose word 17 is stuck-corrupted to 0xAA
  always @(posedge sys_clk) begin
    if (wr_en) mem[addr] <= (addr == 8'd17) ? 8'hAA : data;
    if (rd_en) r1 <= mem[addr];
    rd_q <= r1;
  end
`endif
  ram_seq_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_MAX(3)
`ifdef RAM_CHECK_EN
    , .RD_LAT(2)
`endif
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .key1_flag(key1_flag), .key2_flag(key2_flag),
`ifdef RAM_CHECK_EN
    .rd_q(rd_q), .err(err), .err_addr(err_addr),
`endif
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .data(data), .busy(busy)
  );
  always #5 sys_clk = ~sys_clk;

  task automatic test_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key1_flag = i[0];
      key2_flag = !i[0];
      @(negedge sys_clk);
    end
    key1_flag = 1'b0;
    key2_flag = 1'b0;
    checks++;
    if ({wr_en, rd_en, busy, addr, data} !== '0) begin
      errors++;
      $display("FAIL reset_hold: wr=%b rd=%b busy=%b addr=%0d data=%0d, expected all 0", wr_en, rd_en, busy, addr, data);
    end
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({wr_en, rd_en, busy, addr, data} !== '0) begin
      errors++;
      $display("FAIL reset_idle: wr=%b rd=%b busy=%b addr=%0d data=%0d, expected all 0", wr_en, rd_en, busy, addr, data);
    end
  endtask

  // key1 at sweep address 100 and key2 at 50 must not disturb the sweep
  task automatic test_write_sweep();
    key1_flag = 1'b1;
    @(negedge sys_clk);
    key1_flag = 1'b0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (wr_en !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b1 || addr !== k[7:0] || data !== k[7:0]) begin
        errors++;
        $display("FAIL sweep k=%0d: wr=%b rd=%b busy=%b addr=%0d data=%0d, expected wr=1 rd=0 busy=1 addr=data=%0d", k, wr_en, rd_en, busy, addr, data, k);
      end
      key1_flag = (k == 100);
      key2_flag = (k == 50);
      @(negedge sys_clk);
    end
    key1_flag = 1'b0;
    key2_flag = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || rd_en !== 1'b1 || busy !== 1'b0 || addr !== 8'd0) begin
      errors++;
      $display("FAIL sweep_end: wr=%b rd=%b busy=%b addr=%0d, expected wr=0 rd=1 busy=0 addr=0", wr_en, rd_en, busy, addr);
    end
  endtask

  task automatic test_read_pacing();
    for (n = 0; n < 1028; n++) begin
      checks++;
      if (rd_en !== 1'b1 || wr_en !== 1'b0 || addr !== 8'((n / 4) % 256)) begin
        errors++;
        $display("FAIL pacing n=%0d: rd=%b wr=%b addr=%0d, expected rd=1 wr=0 addr=%0d", n, rd_en, wr_en, addr, (n / 4) % 256);
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_pause();
    while (n < 1046) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (addr !== 8'd5) begin
      errors++;
      $display("FAIL pause_pre: addr=%0d, expected 5", addr);
    end
    key2_flag = 1'b1;
    @(negedge sys_clk);
    key2_flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (addr !== 8'd5 || rd_en !== 1'b1) begin
        errors++;
        $display("FAIL pause_hold i=%0d: addr=%0d rd=%b, expected addr=5 rd=1", i, addr, rd_en);
      end
      @(negedge sys_clk);
    end
    key2_flag = 1'b1;
    @(negedge sys_clk);
    key2_flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr !== (i == 2 ? 8'd6 : 8'd5)) begin
        errors++;
        $display("FAIL resume i=%0d: addr=%0d, expected %0d", i, addr, i == 2 ? 6 : 5);
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_priority_and_abort();
    key1_flag = 1'b1;
    key2_flag = 1'b1;
    @(negedge sys_clk);
    key1_flag = 1'b0;
    key2_flag = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b1 || addr !== 8'd0 || data !== 8'd0) begin
      errors++;
      $display("FAIL priority: wr=%b rd=%b busy=%b addr=%0d data=%0d, expected wr=1 rd=0 busy=1 addr=0 data=0", wr_en, rd_en, busy, addr, data);
    end
    repeat (40) @(negedge sys_clk);
    checks++;
    if (addr !== 8'd40 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: addr=%0d wr=%b, expected addr=40 wr=1", addr, wr_en);
    end
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({wr_en, rd_en, busy, addr, data} !== '0) begin
      errors++;
      $display("FAIL abort_reset: wr=%b rd=%b busy=%b addr=%0d data=%0d, expected all 0", wr_en, rd_en, busy, addr, data);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({wr_en, rd_en, busy, addr, data} !== '0) begin
      errors++;
      $display("FAIL abort_idle: wr=%b rd=%b busy=%b addr=%0d data=%0d, expected all 0", wr_en, rd_en, busy, addr, data);
    end
  endtask

  task automatic test_idle_read();
    key2_flag = 1'b1;
    @(negedge sys_clk);
    key2_flag = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || addr !== 8'd0 || data !== 8'd0) begin
      errors++;
      $display("FAIL idle_read: rd=%b wr=%b busy=%b addr=%0d data=%0d, expected rd=1 wr=0 busy=0 addr=0 data=0", rd_en, wr_en, busy, addr, data);
    end
    repeat (4) @(negedge sys_clk);
    checks++;
    if (addr !== 8'd1) begin
      errors++;
      $display("FAIL idle_read_step: addr=%0d, expected 1", addr);
    end
  endtask

`ifdef RAM_CHECK_EN
  task automatic test_checker();
    key1_flag = 1'b1;
    @(negedge sys_clk);
    key1_flag = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL chk_clear: err=%b, expected 0", err);
    end
    repeat (256) @(negedge sys_clk);
    for (n = 0; n <= 1100; n++) begin
      if (n == 60) begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL chk_early: err=%b, expected 0", err);
        end
      end
      if (n == 80 || n == 1100) begin
        checks++;
        if (err !== 1'b1 || err_addr !== 8'd17) begin
          errors++;
          $display("FAIL chk_err n=%0d: err=%b err_addr=%0d, expected err=1 err_addr=17", n, err, err_addr);
        end
      end
      @(negedge sys_clk);
    end
    key1_flag = 1'b1;
    @(negedge sys_clk);
    key1_flag = 1'b0;
    checks++;
    if (err !== 1'b0 || err_addr !== 8'd0) begin
      errors++;
      $display("FAIL chk_rearm: err=%b err_addr=%0d, expected err=0 err_addr=0", err, err_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_sweep();
    test_read_pacing();
    test_pause();
    test_priority_and_abort();
    test_idle_read();
`ifdef RAM_CHECK_EN
    test_checker();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
